edge_stream_sequencer: RTL and testbench
========================================

Name: edge_stream_sequencer

Overview:
Frame-level controller in front of edge_filter. Accepts the raw 12-bit RGB444 camera pixel stream and regenerates Avalon-ST framing (valid, startofpacket, endofpacket) from pixel/line counters. Enforces an inter-frame gap so the filter line buffers can drain. Changes the filter kernel select (freq_flag) only at frame boundaries, so a frame is never processed with mixed kernels.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
GAP_CYCLES, 16, idle cycles forced between frames (must be >= 1)
MODE_MAX, 3, highest legal freq_flag value

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
pix_valid_in  in  1  camera pixel valid
pix_sof_in  in  1  camera first-pixel-of-frame marker, qualified by pix_valid_in
pix_data_in  in  12  camera pixel
pix_ready_out  out  1  backpressure to camera
flt_ready_in  in  1  filter accepts a pixel
flt_valid_out  out  1  pixel valid to filter
flt_sop_out  out  1  startofpacket to filter
flt_eop_out  out  1  endofpacket to filter
flt_data_out  out  12  pixel to filter
flt_freq_flag  out  3  kernel select to filter; stable for a whole frame
mode_req  in  3  requested kernel select
mode_req_strobe  in  1  one-cycle request pulse
frame_count  out  16  completed frames; wraps 0xFFFF->0
frame_err  out  1  sticky: early SOF seen mid-frame
cfg_err  out  1  sticky: illegal mode_req (> MODE_MAX) rejected
busy  out  1  high in S_STREAM or S_GAP

Behaviour:
- Reset (async, rst_n=0) sets: state=S_IDLE, x=y=0, flt_freq_flag=0, pending_valid=0, frame_count=0, both error flags=0. Combinational outputs evaluate from these values.
- Datapath is combinational pass-through, latency 0:
  - flt_data_out = pix_data_in.
  - Transfer occurs when flt_valid_out && flt_ready_in.
- S_IDLE (sync hunt):
  - pix_ready_out = pix_sof_in ? flt_ready_in : 1. Pixels without SOF are dropped silently.
  - flt_valid_out = pix_valid_in && pix_sof_in.
  - A transfer emits sop=1, sets x=1, y=0, and moves to S_STREAM.
- S_STREAM:
  - pix_ready_out = flt_ready_in; flt_valid_out = pix_valid_in.
  - sop = (x==0 && y==0); eop = (x==IMG_WIDTH-1 && y==IMG_HEIGHT-1).
  - On each transfer x increments; at IMG_WIDTH-1, x wraps to 0 and y increments.
  - On the eop transfer: frame_count++, load gap counter with GAP_CYCLES-1, go to S_GAP.
- Early SOF: pix_valid_in && pix_sof_in in S_STREAM with (x,y) != (0,0).
  - Set frame_err (sticky).
  - Treat that pixel as a new frame start: sop=1, x=1, y=0.
  - frame_count is not incremented; flt_freq_flag is unchanged.
- S_GAP:
  - pix_ready_out=0, flt_valid_out=0.
  - Counter decrements each cycle. At 0: if pending_valid, flt_freq_flag <= pending and pending_valid <= 0. Then go to S_IDLE.
- Mode requests:
  - A strobe with mode_req <= MODE_MAX loads pending and sets pending_valid. A later strobe overwrites an earlier one (last wins).
  - A strobe with mode_req > MODE_MAX is ignored and sets cfg_err.
  - Strobe in the same cycle as the gap apply: the old pending value is applied, and the new value stays pending for the next frame.
- flt_sop_out and flt_eop_out are 0 whenever flt_valid_out is 0.
- Backpressure: counters advance only on transfer. Holding flt_ready_in=0 freezes all state except S_GAP counting.
- rst_n asserted mid-frame aborts immediately with no eop. The next frame requires a new SOF.

Decomposition:
- Package edge_seq_pkg holds:
  - typedef state_t {S_IDLE, S_STREAM, S_GAP}
  - typedef freq_flag_t logic[2:0], plus constants FF_NONE=0, FF_3X3=1, FF_5X5=2, FF_7X7=3
  - localparam PIX_W=12
- One natural sub-module, frame_pos_counter: x/y counters with advance and restart inputs, producing is_first and is_last.

Test Plan (bench params IMG_WIDTH=8, IMG_HEIGHT=4, GAP_CYCLES=4):
- Full frame, flt_ready_in=1, SOF on pixel 0 -> 32 transfers; sop on transfer 1 only, eop on transfer 32 only; frame_count=1; pix_ready_out=0 for exactly 4 cycles afterwards.
- Pixels without SOF after reset -> all dropped (pix_ready_out=1, flt_valid_out=0); first SOF pixel produces sop.
- mode_req=2 strobed mid-frame -> flt_freq_flag stays 0 through eop and becomes 2 on the last gap cycle. Then strobe 5 -> cfg_err=1, flag stays 2.
- Early SOF at pixel 13 -> frame_err=1, sop re-emitted on that pixel; eop follows 31 transfers later; frame_count unchanged until that eop.
- Random flt_ready_in deassertion (50%) -> exactly 32 transfers per frame, data order preserved, no sop/eop while flt_valid_out=0.
- rst_n pulsed low at pixel 10 -> outputs return to reset values asynchronously; stream resumes only at the next SOF with flt_freq_flag=0.

Source files
------------

// File: rtl/edge_stream_sequencer_pkg.sv
// Shared types and constants for the edge_filter front-end sequencer.
package edge_seq_pkg;

    localparam int PIX_W = 12;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    typedef logic [2:0] freq_flag_t;

    localparam freq_flag_t FF_NONE = 3'd0;
    localparam freq_flag_t FF_3X3  = 3'd1;
    localparam freq_flag_t FF_5X5  = 3'd2;
    localparam freq_flag_t FF_7X7  = 3'd3;

    // True when a requested kernel select is within the supported range.
    function automatic logic mode_is_legal(freq_flag_t mode, int unsigned max_mode);
        return {29'd0, mode} <= max_mode;
    endfunction

endpackage

// File: rtl/edge_stream_sequencer_if.sv
// Pixel stream bundle: camera-side input stream and filter-side Avalon-ST output.
interface edge_stream_sequencer_if;
    import edge_seq_pkg::*;

    logic             pix_valid_in;
    logic             pix_sof_in;
    logic [PIX_W-1:0] pix_data_in;
    logic             pix_ready_out;

    logic             flt_ready_in;
    logic             flt_valid_out;
    logic             flt_sop_out;
    logic             flt_eop_out;
    logic [PIX_W-1:0] flt_data_out;

    // Sequencer side.
    modport slave (
        input  pix_valid_in, pix_sof_in, pix_data_in, flt_ready_in,
        output pix_ready_out, flt_valid_out, flt_sop_out, flt_eop_out, flt_data_out
    );

    // Camera + filter side (environment).
    modport master (
        output pix_valid_in, pix_sof_in, pix_data_in, flt_ready_in,
        input  pix_ready_out, flt_valid_out, flt_sop_out, flt_eop_out, flt_data_out
    );

endinterface

// File: rtl/edge_stream_sequencer_frame_pos_counter.sv
// Raster position tracker: x/y within the frame, advanced once per transferred pixel.
module frame_pos_counter #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,   // a pixel at the current position was transferred
    input  logic restart,   // a frame-start pixel was transferred; next position follows (0,0)
    output logic is_first,
    output logic is_last
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] x, base_x, next_x;
    logic [YW-1:0] y, base_y, next_y;

    // Position following either the current pixel or, on restart, the frame origin.
    // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        base_x = restart ? '0 : x;
        base_y = restart ? '0 : y;
        next_x = base_x + XW'(1);
        next_y = base_y;
        if (base_x == X_LAST) begin
            next_x = '0;
            next_y = (base_y == Y_LAST) ? '0 : base_y + YW'(1);
        end
    end

    // Position register; frozen unless a pixel actually moves.
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (advance || restart) begin
            x <= next_x;
            y <= next_y;
        end
    end

    assign is_first = (x == '0) && (y == '0);
    assign is_last  = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/edge_stream_sequencer.sv
// Frame-level controller in front of edge_filter: regenerates SOP/EOP framing,
// forces an inter-frame gap, and switches the kernel select only between frames.
module edge_stream_sequencer
    import edge_seq_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int GAP_CYCLES = 16,
    parameter int MODE_MAX   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    edge_stream_sequencer_if.slave bus,
    output freq_flag_t             flt_freq_flag,
    input  freq_flag_t             mode_req,
    input  logic                   mode_req_strobe,
    output logic [15:0]            frame_count,
    output logic                   frame_err,
    output logic                   cfg_err,
    output logic                   busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t      state, state_nx;
    logic [GW-1:0] gap_cnt;
    freq_flag_t  pending;
    logic        pending_valid;

    logic is_first, is_last;
    logic pos_advance, pos_restart;
    logic early_sof_xfer;   // mid-frame SOF pixel transferred
    logic frame_done;       // EOP pixel transferred
    logic gap_apply;        // last gap cycle: pending kernel select takes effect
    logic mode_legal;

    frame_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (pos_advance),
        .restart  (pos_restart),
        .is_first (is_first),
        .is_last  (is_last)
    );

    // Latency-0 pixel pass-through; framing is added alongside.
    assign bus.flt_data_out = bus.pix_data_in;

    assign busy       = (state != S_IDLE);
    assign gap_apply  = (state == S_GAP) && (gap_cnt == '0);
    assign mode_legal = mode_is_legal(mode_req, MODE_MAX);

    // Handshake, framing flags and next state for the current stream phase.
    always_comb begin
        bus.pix_ready_out  = 1'b0;
        bus.flt_valid_out  = 1'b0;
        bus.flt_sop_out    = 1'b0;
        bus.flt_eop_out    = 1'b0;
        state_nx           = state;
        pos_advance        = 1'b0;
        pos_restart        = 1'b0;
        early_sof_xfer     = 1'b0;
        frame_done         = 1'b0;

        unique case (state)
            S_IDLE: begin
                // Hunt for SOF; anything else is swallowed without reaching the filter.
                bus.pix_ready_out = bus.pix_sof_in ? bus.flt_ready_in : 1'b1;
                bus.flt_valid_out = bus.pix_valid_in && bus.pix_sof_in;
                bus.flt_sop_out   = bus.flt_valid_out;
                if (bus.flt_valid_out && bus.flt_ready_in) begin
                    pos_restart = 1'b1;
                    state_nx    = S_STREAM;
                end
            end

            S_STREAM: begin
                bus.pix_ready_out = bus.flt_ready_in;
                bus.flt_valid_out = bus.pix_valid_in;
                if (bus.pix_valid_in) begin
                    // A SOF away from the origin resynchronises rather than closing the frame.
                    if (bus.pix_sof_in && !is_first) begin
                        bus.flt_sop_out = 1'b1;
                        if (bus.flt_ready_in) begin
                            early_sof_xfer = 1'b1;
                            pos_restart    = 1'b1;
                        end
                    end else begin
                        bus.flt_sop_out = is_first;
                        bus.flt_eop_out = is_last;
                        if (bus.flt_ready_in) begin
                            pos_advance = 1'b1;
                            if (is_last) begin
                                frame_done = 1'b1;
                                state_nx   = S_GAP;
                            end
                        end
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = S_IDLE;
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // Stream phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Inter-frame gap countdown; runs regardless of filter backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (frame_done) begin
            gap_cnt <= GW'(GAP_CYCLES - 1);
        end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // Completed-frame counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            frame_err   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (early_sof_xfer) begin
                frame_err <= 1'b1;
            end
            if (mode_req_strobe && !mode_legal) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Kernel select: requests queue up and take effect only on the last gap cycle.
    // A request landing on that same cycle waits for the following frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_freq_flag <= FF_NONE;
            pending       <= FF_NONE;
            pending_valid <= 1'b0;
        end else begin
            if (gap_apply && pending_valid) begin
                flt_freq_flag <= pending;
            end
            if (mode_req_strobe && mode_legal) begin
                pending       <= mode_req;
                pending_valid <= 1'b1;
            end else if (gap_apply) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_stream_sequencer.sv
// Self-checking bench for edge_stream_sequencer: a pixel-order reference model
// predicts every filter-side beat; a monitor compares beats as the DUT emits them.
module tb_edge_stream_sequencer;
    import edge_seq_pkg::*;

    localparam int W        = 8;
    localparam int H        = 4;
    localparam int G        = 4;
    localparam int MODE_MAX = 3;
    localparam int N        = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_stream_sequencer_if bus ();

    freq_flag_t  flt_freq_flag;
    freq_flag_t  mode_req;
    logic        mode_req_strobe;
    logic [15:0] frame_count;
    logic        frame_err;
    logic        cfg_err;
    logic        busy;

    edge_stream_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .GAP_CYCLES (G),
        .MODE_MAX   (MODE_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .flt_freq_flag   (flt_freq_flag),
        .mode_req        (mode_req),
        .mode_req_strobe (mode_req_strobe),
        .frame_count     (frame_count),
        .frame_err       (frame_err),
        .cfg_err         (cfg_err),
        .busy            (busy)
    );

    typedef struct {
        logic [11:0] data;
        logic        sop;
        logic        eop;
        freq_flag_t  flag;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Reference model: frame position counted in pixels, kernel changes at frame end.
    bit         m_in_frame;
    int         m_pos;
    freq_flag_t m_flag;
    freq_flag_t m_pending;
    bit         m_pending_valid;
    bit         m_frame_err;
    bit         m_cfg_err;
    int         m_frames;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_frame      = 1'b0;
        m_pos           = 0;
        m_flag          = FF_NONE;
        m_pending       = FF_NONE;
        m_pending_valid = 1'b0;
        m_frame_err     = 1'b0;
        m_cfg_err       = 1'b0;
        m_frames        = 0;
        exp_q.delete();
    endfunction

    function automatic void model_strobe(input freq_flag_t m);
        if (int'(m) <= MODE_MAX) begin
            m_pending       = m;
            m_pending_valid = 1'b1;
        end else begin
            m_cfg_err = 1'b1;
        end
    endfunction

    function automatic void model_pixel(input logic [11:0] d, input logic sof);
        bit last;
        if (!m_in_frame) begin
            if (sof) begin
                exp_q.push_back('{data: d, sop: 1'b1, eop: 1'b0, flag: m_flag});
                m_in_frame = 1'b1;
                m_pos      = 1;
            end
        end else if (sof) begin
            m_frame_err = 1'b1;
            exp_q.push_back('{data: d, sop: 1'b1, eop: 1'b0, flag: m_flag});
            m_pos = 1;
        end else begin
            last = (m_pos == N - 1);
            exp_q.push_back('{data: d, sop: 1'b0, eop: last, flag: m_flag});
            m_pos++;
            if (last) begin
                m_frames++;
                m_in_frame = 1'b0;
                if (m_pending_valid) begin
                    m_flag          = m_pending;
                    m_pending_valid = 1'b0;
                end
            end
        end
    endfunction

    // Presents one camera pixel until accepted; optional mode strobe on its first cycle.
    // Entered and left one time unit after a rising edge.
    task automatic send_pixel(input logic [11:0] d, input logic sof, input bit stb,
                              input freq_flag_t m, output int waited);
        bit acc;
        bus.pix_valid_in = 1'b1;
        bus.pix_sof_in   = sof;
        bus.pix_data_in  = d;
        if (stb) begin
            mode_req        = m;
            mode_req_strobe = 1'b1;
            model_strobe(m);
        end
        model_pixel(d, sof);
        waited = 0;
        forever begin
            @(negedge clk);
            acc = bus.pix_ready_out;
            @(posedge clk);
            #1;
            mode_req_strobe = 1'b0;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check("pixel_accept_timeout", 32'(waited), 32'(0));
                break;
            end
        end
        bus.pix_valid_in = 1'b0;
        bus.pix_sof_in   = 1'b0;
    endtask

    task automatic strobe_idle(input freq_flag_t m);
        mode_req        = m;
        mode_req_strobe = 1'b1;
        model_strobe(m);
        @(posedge clk);
        #1;
        mode_req_strobe = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] base, input int stb_pos, input freq_flag_t m);
        int w;
        for (int i = 0; i < N; i++) begin
            send_pixel(base + 12'(i), (i == 0), (i == stb_pos), m, w);
        end
    endtask

    // Filter-side ready: always high, or a fair coin per cycle.
    initial begin
        bus.flt_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.flt_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every transfer must match the next predicted beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.flt_valid_out) begin
                    if (bus.flt_ready_in) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_transfer", 32'(bus.flt_data_out), 32'hFFFF_FFFF);
                        end else begin
                            b = exp_q.pop_front();
                            check("beat_data", 32'(bus.flt_data_out), 32'(b.data));
                            check("beat_sop",  32'(bus.flt_sop_out),  32'(b.sop));
                            check("beat_eop",  32'(bus.flt_eop_out),  32'(b.eop));
                            check("beat_flag", 32'(flt_freq_flag),    32'(b.flag));
                        end
                    end
                end else begin
                    check("framing_without_valid", 32'({bus.flt_sop_out, bus.flt_eop_out}), 32'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int junk;
        int spos;
        bus.pix_valid_in = 1'b0;
        bus.pix_sof_in   = 1'b0;
        bus.pix_data_in  = '0;
        mode_req         = '0;
        mode_req_strobe  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", 32'(bus.pix_ready_out), 32'(1));
        check("rst_valid",     32'(bus.flt_valid_out), 32'(0));
        check("rst_busy",      32'(busy),              32'(0));
        check("rst_frames",    32'(frame_count),       32'(0));
        check("rst_flag",      32'(flt_freq_flag),     32'(0));
        check("rst_errs",      32'({frame_err, cfg_err}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sync hunt, then a clean frame with a mid-frame kernel request.
        for (int i = 0; i < 3; i++) begin
            send_pixel(12'h100 + 12'(i), 1'b0, 1'b0, FF_NONE, w);
            check("hunt_drop_wait", 32'(w), 32'(0));
        end
        check("hunt_busy", 32'(busy), 32'(0));
        send_frame(12'h200, 5, FF_5X5);
        check("f1_frame_count", 32'(frame_count), 32'(m_frames));
        check("f1_flag_at_eop", 32'(flt_freq_flag), 32'(FF_NONE));
        check("f1_busy_in_gap", 32'(busy), 32'(1));
        send_pixel(12'h2FF, 1'b0, 1'b0, FF_NONE, w);
        check("gap_length", 32'(w), 32'(G));
        check("flag_after_gap", 32'(flt_freq_flag), 32'(m_flag));
        strobe_idle(3'd5);
        check("cfg_err_set", 32'(cfg_err), 32'(m_cfg_err));
        check("flag_after_illegal", 32'(flt_freq_flag), 32'(m_flag));

        // Early SOF at pixel 13 restarts the frame.
        for (int i = 0; i < 13; i++) begin
            send_pixel(12'h300 + 12'(i), (i == 0), 1'b0, FF_NONE, w);
        end
        send_pixel(12'h3AA, 1'b1, 1'b0, FF_NONE, w);
        check("early_sof_frame_err", 32'(frame_err), 32'(m_frame_err));
        check("early_sof_count_held", 32'(frame_count), 32'(m_frames));
        for (int i = 1; i < N; i++) begin
            send_pixel(12'h400 + 12'(i), 1'b0, 1'b0, FF_NONE, w);
        end
        check("early_sof_frame_done", 32'(frame_count), 32'(m_frames));
        send_pixel(12'h4FF, 1'b0, 1'b0, FF_NONE, w);
        check("gap_length_2", 32'(w), 32'(G));

        // Randomised backpressure, data, junk and kernel requests.
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            junk = $urandom_range(0, 3);
            for (int j = 0; j < junk; j++) begin
                send_pixel(12'($urandom), 1'b0, 1'b0, FF_NONE, w);
            end
            spos = $urandom_range(1, N - 2);
            send_frame(12'($urandom), spos, (f == 2) ? FF_7X7 : freq_flag_t'($urandom_range(0, 7)));
            check("rand_frame_count", 32'(frame_count), 32'(m_frames));
            check("rand_cfg_err", 32'(cfg_err), 32'(m_cfg_err));
            send_pixel(12'($urandom), 1'b0, 1'b0, FF_NONE, w);
            check("rand_flag_after_gap", 32'(flt_freq_flag), 32'(m_flag));
        end

        // Asynchronous reset in the middle of a frame.
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            send_pixel(12'h500 + 12'(i), (i == 0), 1'b0, FF_NONE, w);
        end
        bus.pix_valid_in = 1'b1;
        bus.pix_sof_in   = 1'b0;
        bus.pix_data_in  = 12'h50A;
        #1;
        check("pre_reset_streaming", 32'(bus.flt_valid_out), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.flt_valid_out), 32'(0));
        check("async_rst_ready", 32'(bus.pix_ready_out), 32'(1));
        check("async_rst_busy",  32'(busy),              32'(0));
        check("async_rst_count", 32'(frame_count),       32'(0));
        check("async_rst_flag",  32'(flt_freq_flag),     32'(0));
        check("async_rst_errs",  32'({frame_err, cfg_err}), 32'(0));
        bus.pix_valid_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_pixel(12'h600 + 12'(i), 1'b0, 1'b0, FF_NONE, w);
        end
        send_frame(12'h700, -1, FF_NONE);
        send_pixel(12'h7FF, 1'b0, 1'b0, FF_NONE, w);
        check("post_rst_frame_count", 32'(frame_count), 32'(m_frames));
        check("post_rst_flag", 32'(flt_freq_flag), 32'(m_flag));

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
